// File: rtl/obc_pkg.sv
// Shared types and constants for the OBC distributed-arithmetic DFT sequencer.
package obc_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned NLANE = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef logic signed [ACC_W-1:0] lane_word_t;

endpackage

// File: rtl/obc_da_sequencer_if.sv
// Frame-in / result-out handshake bundle of the OBC DA sequencer.
interface obc_da_sequencer_if
    import obc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
);

    logic                     in_valid;
    logic                     in_ready;
    logic [8*DATA_W-1:0]      in_data;
    logic [NLANE*ACC_W-1:0]   offset;
    logic                     out_valid;
    logic                     out_ready;
    logic [NLANE*ACC_W-1:0]   out_data;

    // master: the sample buffer / downstream side; slave: the sequencer
    modport master (
        output in_valid, in_data, offset, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, offset, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/obc_lane_acc.sv
// Single-lane shift-add accumulator: halving add per bit, subtract + offset on the sign bit.
module obc_lane_acc
    import obc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step,
    input  logic       last,
    input  lane_word_t rom,
    input  lane_word_t offset,
    output lane_word_t acc
);

    lane_word_t acc_q, acc_d, sum;

    always_comb begin
        sum   = acc_q + rom;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            // sign-bit slice carries negative weight; offset folds in the OBC correction
            if (last) begin
                acc_d = acc_q - rom + offset;
            end else begin
                acc_d = sum >>> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/obc_da_sequencer.sv
// Bit-serial OBC DA controller: shifts a frame of 8 samples out LSB first as ROM addresses
// and accumulates the returned lane words into finished DFT lane results.
module obc_da_sequencer
    import obc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    obc_da_sequencer_if.slave      bus,
    output logic [7:0]             rom_bits,
    input  logic [NLANE*ACC_W-1:0] rom_data,
    output logic                   busy
);

    localparam int unsigned   CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sreg_q [8];
    logic [CNT_W-1:0]  k_q;
    lane_word_t        off_q [NLANE];
    lane_word_t        acc [NLANE];
    logic              load, clr, step, last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        load          = 1'b0;
        clr           = 1'b0;
        step          = 1'b0;
        last          = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (k_q == K_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample shift registers, bit counter and per-lane offsets captured with the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q <= '0;
            for (int i = 0; i < 8; i++) begin
                sreg_q[i] <= '0;
            end
            for (int l = 0; l < int'(NLANE); l++) begin
                off_q[l] <= '0;
            end
        end else if (load) begin
            k_q <= '0;
            for (int i = 0; i < 8; i++) begin
                sreg_q[i] <= bus.in_data[i*DATA_W +: DATA_W];
            end
            for (int l = 0; l < int'(NLANE); l++) begin
                off_q[l] <= lane_word_t'(bus.offset[l*ACC_W +: ACC_W]);
            end
        end else if (step) begin
            k_q <= k_q + 1'b1;
            for (int i = 0; i < 8; i++) begin
                sreg_q[i] <= sreg_q[i] >> 1;
            end
        end
    end

    always_comb begin
        rom_bits = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < 8; i++) begin
                rom_bits[i] = sreg_q[i][0];
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        if (state_q == DONE) begin
            for (int l = 0; l < int'(NLANE); l++) begin
                bus.out_data[l*ACC_W +: ACC_W] = acc[l];
            end
        end
    end

    for (genvar l = 0; l < int'(NLANE); l++) begin : g_lane
        obc_lane_acc u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .step   (step),
            .last   (last),
            .rom    (lane_word_t'(rom_data[l*ACC_W +: ACC_W])),
            .offset (off_q[l]),
            .acc    (acc[l])
        );
    end

endmodule

// File: tb/tb_obc_da_sequencer.sv
// Directed, table-driven bench for obc_da_sequencer at DATA_W=4 with a bit-dependent ROM model.
module tb_obc_da_sequencer;
    import obc_pkg::*;

    localparam int unsigned DW = 4;

    typedef struct {
        logic [8*DW-1:0]        frame;
        logic [NLANE*ACC_W-1:0] offs;
        logic [NLANE*ACC_W-1:0] base;
        logic [31:0]            bits;  // expected rom_bits, RUN cycle c at [8c +: 8]
        logic [NLANE*ACC_W-1:0] exp;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [7:0]             rom_bits;
    logic [NLANE*ACC_W-1:0] rom_data;
    logic [NLANE*ACC_W-1:0] base_cur;
    logic                   busy;

    int nchecks = 0;
    int nerr    = 0;
    vec_t vecs [4];

    obc_da_sequencer_if #(.DATA_W(DW)) bus ();

    obc_da_sequencer #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_bits (rom_bits),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Lane 0 also depends on the address so slice ordering shows up in results
    assign rom_data = base_cur + {112'h0, rom_bits, 8'h00};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at the negedge of RUN cycle 0; leaves at the first DONE negedge.
    task automatic run_body(input int v);
        for (int c = 0; c < int'(DW); c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("v%0d rom_bits c%0d", v, c), 128'(rom_bits), 128'(vecs[v].bits[8*c +: 8]));
            check($sformatf("v%0d run flags c%0d", v, c),
                  128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b001));
        end
        @(negedge clk);
        check($sformatf("v%0d done flags", v),
              128'({bus.out_valid, bus.in_ready, busy, rom_bits}), 128'({3'b101, 8'h00}));
        check($sformatf("v%0d out_data", v), bus.out_data, vecs[v].exp);
    endtask

    task automatic release_out(input int v);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check($sformatf("v%0d back to idle", v),
              128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b010));
    endtask

    task automatic present(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[v].frame;
        bus.offset   = vecs[v].offs;
        base_cur     = vecs[v].base;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // constant ROM 0x100: 128, 192, 224, 224-256 = -32 on every lane
        vecs[0] = '{32'h0, 128'h0, {4{32'h00000100}}, 32'h0, {4{32'hFFFFFFE0}}};
        // offset path only
        vecs[1] = '{32'h0, {32'h0, 32'h12345678, 32'h0, 32'h0}, 128'h0, 32'h0,
                    {32'h0, 32'h12345678, 32'h0, 32'h0}};
        // x0=0001, x7=1000: lane0 sees 0x100,0,0,0x8000 -> 0x20-0x8000
        vecs[2] = '{32'h8000_0001, 128'h0, 128'h0, 32'h80_00_00_01,
                    {32'h0, 32'h0, 32'h0, 32'hFFFF8020}};
        // x1=1111: negative, odd and offset lanes
        vecs[3] = '{32'h0000_00F0, {32'h0, 32'h0, 32'h10, 32'h0},
                    {32'hFFFFFF00, 32'h3, 32'h40, 32'h0}, 32'h02_02_02_02,
                    {32'h20, 32'hFFFFFFFF, 32'h8, 32'hFFFFFFC0}};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.offset    = '0;
        bus.out_ready = 1'b0;
        base_cur      = '0;
        repeat (2) @(negedge clk);
        check("reset flags", 128'({bus.in_ready, bus.out_valid, busy, rom_bits}),
              128'({3'b100, 8'h00}));
        check("reset out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            check($sformatf("v%0d idle ready", v), 128'(bus.in_ready), 128'(1'b1));
            present(v);
            @(negedge clk);
            bus.in_valid = 1'b0;
            run_body(v);
            release_out(v);
        end

        // Backpressure: hold DONE for 10 cycles with a new frame offered, then hand off
        @(negedge clk);
        present(0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        run_body(0);
        present(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hold flags c%0d", c),
                  128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b101));
            check($sformatf("hold data c%0d", c), bus.out_data, vecs[0].exp);
        end
        release_out(30);
        @(negedge clk);
        bus.in_valid = 1'b0;
        run_body(3);
        release_out(3);

        // Reset in RUN cycle 2 aborts the frame
        @(negedge clk);
        present(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort busy", 128'(busy), 128'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort flags", 128'({bus.in_ready, bus.out_valid, busy, rom_bits}),
              128'({3'b100, 8'h00}));
        check("abort out_data", bus.out_data, 128'h0);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                seen = seen | bus.out_valid | busy;
            end
            check("abort no output", 128'(seen), 128'(1'b0));
        end
        present(3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        run_body(3);
        release_out(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
